iq_issue_scheduler: RTL and testbench

- Issue controller between the instruction_queue head and two execution resources: ALU pipe and memory pipe.
- Holds a 32-entry register scoreboard and checks RAW/WAW hazards on the head entry.
- Routes the entry by HasAddress, issues with a valid/ready handshake, and drives the queue's stall input.
- Supports a drain/flush sequence before the front end is redirected.

---
 rtl/iq_issue_scheduler.sv | 172 +++++++++++++++++
 tb/tb_iq_issue_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_issue_scheduler.sv
// Issue scheduler that sits between the instruction-queue head and the ALU and memory pipes.
// It keeps a 32-entry register scoreboard, caps the number of memory ops in flight, and issues
// through a one-entry output register with a valid/ready handshake. It can also drain and then
// flush before the front end is redirected.
// Define IQ_SCHED_PERF_EN to add the perf_hazard_cycles, perf_full_cycles and perf_issued
// counters.
module iq_issue_scheduler #(
  parameter int unsigned MEM_MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W              = 48
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                iq_valid,
  input  logic [3:0]          MajorOpcode_in,
  input  logic [3:0]          MinorOpcode_in,
  input  logic [4:0]          Source1_in,
  input  logic [4:0]          Source2_in,
  input  logic [4:0]          Destination_in,
  input  logic [1:0]          OffsetScale_in,
  input  logic                OffsetSub_in,
  input  logic                HasAddress_in,
  input  logic [ADDR_W-1:0]   Address_in,
  output logic                stall_out,
  output logic                alu_valid,
  input  logic                alu_ready,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31+ADDR_W-1:0] issue_bus,
  input  logic                wb_valid,
  input  logic [4:0]          wb_dest,
  input  logic                wb_is_mem,
  input  logic                flush_req,
  output logic                flush_done
`ifdef IQ_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_hazard_cycles,
  output logic [31:0]         perf_full_cycles,
  output logic [31:0]         perf_issued
`endif
);

  localparam int unsigned BusW   = 31 + ADDR_W;
  localparam logic [3:0]  MemMax = 4'(MEM_MAX_OUTSTANDING);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [31:0]       r_busy, w_busy_next;
  logic [3:0]        r_mem_cnt, w_mem_cnt_next;
  logic              r_alu_valid, r_mem_valid;
  logic [BusW-1:0]   r_issue_bus;

  logic              w_hazard;
  logic              w_mem_full;
  logic              w_out_valid;
  logic              w_out_taken;
  logic              w_loadable;
  logic              w_run_ok;
  logic              w_pop;
  logic              w_mem_inc;
  logic              w_mem_dec;
  logic [BusW-1:0]   w_issue_word;

  // Hazard, capacity and pop decision for the current head entry.
  // busy[0] is held at zero, so Dest=0 never produces a WAW hold.
  assign w_hazard    = r_busy[Source1_in] | r_busy[Source2_in] | r_busy[Destination_in];
  assign w_mem_full  = HasAddress_in & (r_mem_cnt == MemMax);
  assign w_out_valid = r_alu_valid | r_mem_valid;
  assign w_out_taken = (r_alu_valid & alu_ready) | (r_mem_valid & mem_ready);
  assign w_loadable  = ~w_out_valid | w_out_taken;
  assign w_run_ok    = (r_state == StRun) & ~flush_req;
  assign w_pop       = reset_n & iq_valid & w_run_ok & ~w_hazard & ~w_mem_full & w_loadable;
  assign stall_out   = ~w_pop;

  assign w_mem_inc   = w_pop & HasAddress_in;
  assign w_mem_dec   = wb_valid & wb_is_mem & (r_mem_cnt != 4'd0);

  // The four spare bits at the top of the bus are always zero.
  assign w_issue_word = {4'b0000, MajorOpcode_in, MinorOpcode_in, Source1_in, Source2_in,
                         Destination_in, OffsetScale_in, OffsetSub_in, HasAddress_in, Address_in};

  assign alu_valid  = r_alu_valid;
  assign mem_valid  = r_mem_valid;
  assign issue_bus  = r_issue_bus;
  assign flush_done = (r_state == StDone);

  // Scoreboard and outstanding-count next state; a set from the pop overrides a same-cycle clear.
  always_comb begin
    w_busy_next = r_busy;
    if (wb_valid) w_busy_next[wb_dest] = 1'b0;
    if (w_pop) w_busy_next[Destination_in] = 1'b1;
    w_busy_next[0] = 1'b0;

    w_mem_cnt_next = r_mem_cnt;
    unique case ({w_mem_inc, w_mem_dec})
      2'b10:   w_mem_cnt_next = r_mem_cnt + 4'd1;
      2'b01:   w_mem_cnt_next = r_mem_cnt - 4'd1;
      default: w_mem_cnt_next = r_mem_cnt;
    endcase
  end

  // Drain/flush FSM next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (flush_req) w_state_next = StDrain;
      StDrain: if (!w_out_valid && (r_busy == 32'd0) && (r_mem_cnt == 4'd0)) begin
                 w_state_next = StDone;
               end
      StDone:  w_state_next = StRun;
      default: w_state_next = StRun;
    endcase
  end

  // State, scoreboard and outstanding-count registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= StRun;
      r_busy    <= 32'd0;
      r_mem_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_busy    <= w_busy_next;
      r_mem_cnt <= w_mem_cnt_next;
    end
  end

  // One-entry output register; it reloads on the same edge as its content is taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_alu_valid <= 1'b0;
      r_mem_valid <= 1'b0;
      r_issue_bus <= '0;
    end else if (w_pop) begin
      r_alu_valid <= ~HasAddress_in;
      r_mem_valid <= HasAddress_in;
      r_issue_bus <= w_issue_word;
    end else if (w_out_taken) begin
      r_alu_valid <= 1'b0;
      r_mem_valid <= 1'b0;
    end
  end

`ifdef IQ_SCHED_PERF_EN
  logic w_hazard_cycle;
  logic w_full_cycle;

  // A full cycle is one where the outstanding limit is the only thing stopping a memory pop.
  assign w_hazard_cycle = iq_valid & (r_state == StRun) & w_hazard;
  assign w_full_cycle   = iq_valid & w_run_ok & ~w_hazard & w_mem_full & w_loadable;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_hazard_cycles <= 32'd0;
      perf_full_cycles   <= 32'd0;
      perf_issued        <= 32'd0;
    end else begin
      if (w_hazard_cycle && (perf_hazard_cycles != 32'hFFFF_FFFF)) begin
        perf_hazard_cycles <= perf_hazard_cycles + 32'd1;
      end
      if (w_full_cycle && (perf_full_cycles != 32'hFFFF_FFFF)) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
      if (w_pop && (perf_issued != 32'hFFFF_FFFF)) begin
        perf_issued <= perf_issued + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// Directed bench for iq_issue_scheduler. It drives inputs just after each rising edge,
// checks stall_out combinationally before the next edge, and checks the registered outputs
// #1 after the edge.
module tb_iq_issue_scheduler;

  localparam int unsigned AW = 48;
  localparam int unsigned BW = 31 + AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          iq_valid;
  logic [3:0]    major, minor;
  logic [4:0]    s1, s2, dest;
  logic [1:0]    scale;
  logic          sub, has_addr;
  logic [AW-1:0] addr;
  logic          stall_out, alu_valid, alu_ready, mem_valid, mem_ready;
  logic [BW-1:0] issue_bus;
  logic          wb_valid, wb_is_mem, flush_req, flush_done;
  logic [4:0]    wb_dest;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_bus;

  always #5 clk = ~clk;

  iq_issue_scheduler #(.MEM_MAX_OUTSTANDING(4), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .iq_valid       (iq_valid),
    .MajorOpcode_in (major),
    .MinorOpcode_in (minor),
    .Source1_in     (s1),
    .Source2_in     (s2),
    .Destination_in (dest),
    .OffsetScale_in (scale),
    .OffsetSub_in   (sub),
    .HasAddress_in  (has_addr),
    .Address_in     (addr),
    .stall_out      (stall_out),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .issue_bus      (issue_bus),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .wb_is_mem      (wb_is_mem),
    .flush_req      (flush_req),
    .flush_done     (flush_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a head entry and records its expected issue_bus image.
  task automatic head(input logic [3:0] ma, input logic [3:0] mi, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic [1:0] sc,
                      input logic sb, input logic ha, input logic [AW-1:0] ad);
    iq_valid = 1'b1; major = ma; minor = mi; s1 = a; s2 = b; dest = d;
    scale = sc; sub = sb; has_addr = ha; addr = ad;
    exp_bus = {4'b0000, ma, mi, a, b, d, sc, sb, ha, ad};
  endtask

  task automatic wb(input logic [4:0] d, input logic m);
    wb_valid = 1'b1; wb_dest = d; wb_is_mem = m;
    tick();
    wb_valid = 1'b0; wb_is_mem = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; iq_valid = 1'b0; major = '0; minor = '0; s1 = '0; s2 = '0; dest = '0;
    scale = '0; sub = 1'b0; has_addr = 1'b0; addr = '0; alu_ready = 1'b1; mem_ready = 1'b1;
    wb_valid = 1'b0; wb_dest = '0; wb_is_mem = 1'b0; flush_req = 1'b0;
    exp_bus = '0;

    // Reset: an independent op is presented but must not pop.
    head(4'h1, 4'h0, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 1'b0, '0);
    tick();
    #1 chk("rst_stall", stall_out, 1'b1);
    tick();
    chk("rst_alu_valid", alu_valid, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_bus", issue_bus, '0);
    chk("rst_flush_done", flush_done, 1'b0);
    reset_n = 1'b1;

    // Independent ALU op pops in the same cycle and appears one cycle later.
    head(4'h1, 4'h2, 5'd1, 5'd2, 5'd3, 2'd1, 1'b1, 1'b0, '0);
    #1 chk("alu_pop_stall", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("alu_valid", alu_valid, 1'b1);
    chk("alu_mem_valid", mem_valid, 1'b0);
    chk("alu_bus", issue_bus, exp_bus);

    // RAW on r3; the writeback does not bypass.
    head(4'h2, 4'h0, 5'd3, 5'd0, 5'd5, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("raw3_stall", stall_out, 1'b1);
    wb_valid = 1'b1; wb_dest = 5'd3;
    #1 chk("raw3_no_bypass", stall_out, 1'b1);
    tick();
    wb_valid = 1'b0;
    chk("alu_taken", alu_valid, 1'b0);
    #1 chk("raw3_release", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("raw3_issue_bus", issue_bus, exp_bus);

    // RAW on r5 held for several cycles, then WAW on r6.
    head(4'h3, 4'h1, 5'd5, 5'd1, 5'd6, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("raw5_stall_a", stall_out, 1'b1);
    tick();
    chk("raw5_stall_b", stall_out, 1'b1);
    tick();
    wb_valid = 1'b1; wb_dest = 5'd5;
    #1 chk("raw5_stall_wb", stall_out, 1'b1);
    tick();
    wb_valid = 1'b0;
    #1 chk("raw5_release", stall_out, 1'b0);
    tick();
    chk("raw5_bus", issue_bus, exp_bus);
    head(4'h9, 4'h0, 5'd1, 5'd2, 5'd6, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("waw6_stall", stall_out, 1'b1);
    iq_valid = 1'b0;
    wb(5'd6, 1'b0);

    // Backpressure: memory op held for three cycles, with a younger op stalled behind it.
    mem_ready = 1'b0;
    head(4'h4, 4'h3, 5'd1, 5'd2, 5'd7, 2'd2, 1'b1, 1'b1, 48'd98);
    #1 chk("bp_pop", stall_out, 1'b0);
    tick();
    chk("bp_mem_valid", mem_valid, 1'b1);
    chk("bp_bus0", issue_bus, exp_bus);
    head(4'h5, 4'h0, 5'd1, 5'd2, 5'd8, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("bp_next_stall", stall_out, 1'b1);
    tick();
    chk("bp_mem_valid1", mem_valid, 1'b1);
    chk("bp_bus1", issue_bus, {4'b0000, 4'h4, 4'h3, 5'd1, 5'd2, 5'd7, 2'd2, 1'b1, 1'b1, 48'd98});
    tick();
    chk("bp_mem_valid2", mem_valid, 1'b1);
    chk("bp_stall2", stall_out, 1'b1);
    mem_ready = 1'b1;
    #1 chk("bp_accept_pop", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("bp_after_mem", mem_valid, 1'b0);
    chk("bp_after_alu", alu_valid, 1'b1);
    chk("bp_after_bus", issue_bus, exp_bus);
    wb(5'd8, 1'b0);
    wb(5'd7, 1'b1);
    // A spurious memory writeback while the count is zero must not wrap.
    wb(5'd0, 1'b1);

    // Outstanding limit: four memory ops fill it and the fifth holds.
    for (int i = 0; i < 4; i++) begin
      head(4'h6, 4'h0, 5'd0, 5'd0, 5'(10 + i), 2'd0, 1'b0, 1'b1, 48'(100 + i));
      #1 chk("lim_pop", stall_out, 1'b0);
      tick();
    end
    head(4'h6, 4'h1, 5'd0, 5'd0, 5'd14, 2'd0, 1'b0, 1'b1, 48'd104);
    #1 chk("lim_full_stall", stall_out, 1'b1);
    tick();
    chk("lim_mem_idle", mem_valid, 1'b0);
    chk("lim_full_stall2", stall_out, 1'b1);
    wb_valid = 1'b1; wb_dest = 5'd10; wb_is_mem = 1'b1;
    #1 chk("lim_wb_same_cycle", stall_out, 1'b1);
    tick();
    wb_valid = 1'b0; wb_is_mem = 1'b0;
    #1 chk("lim_release", stall_out, 1'b0);
    tick();
    chk("lim_fifth_mem", mem_valid, 1'b1);
    chk("lim_fifth_bus", issue_bus, exp_bus);
    head(4'h7, 4'h0, 5'd0, 5'd0, 5'd15, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("lim_alu_pop", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("lim_alu_valid", alu_valid, 1'b1);
    chk("lim_alu_bus", issue_bus, exp_bus);
    wb(5'd11, 1'b1);
    wb(5'd12, 1'b1);
    wb(5'd13, 1'b1);

    // Flush with r14 (memory) and r15 (ALU) still in flight.
    head(4'h8, 4'h0, 5'd1, 5'd2, 5'd16, 2'd0, 1'b0, 1'b0, '0);
    flush_req = 1'b1;
    #1 chk("fl_req_stall", stall_out, 1'b1);
    tick();
    flush_req = 1'b0;
    chk("fl_drain_stall", stall_out, 1'b1);
    chk("fl_done_early", flush_done, 1'b0);
    wb(5'd15, 1'b0);
    chk("fl_done_mid", flush_done, 1'b0);
    wb(5'd14, 1'b1);
    chk("fl_done_late", flush_done, 1'b0);
    tick();
    chk("fl_done_pulse", flush_done, 1'b1);
    chk("fl_done_stall", stall_out, 1'b1);
    tick();
    chk("fl_done_clear", flush_done, 1'b0);
    chk("fl_resume_pop", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("fl_resume_bus", issue_bus, exp_bus);

    // Reset in the middle of a drain, with r16 still busy.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    chk("rd_drain_stall", stall_out, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("rd_alu_valid", alu_valid, 1'b0);
    chk("rd_bus", issue_bus, '0);
    chk("rd_flush_done", flush_done, 1'b0);
    reset_n = 1'b1;
    head(4'hA, 4'h0, 5'd16, 5'd0, 5'd17, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("rd_pop", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("rd_alu_issue", alu_valid, 1'b1);
    chk("rd_issue_bus", issue_bus, exp_bus);
    chk("rd_no_flush_done", flush_done, 1'b0);

    // Writing r0 never marks it busy.
    head(4'hB, 4'h0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("r0_pop_a", stall_out, 1'b0);
    tick();
    head(4'hC, 4'h0, 5'd0, 5'd1, 5'd0, 2'd0, 1'b0, 1'b0, '0);
    #1 chk("r0_pop_b", stall_out, 1'b0);
    tick();
    iq_valid = 1'b0;
    chk("r0_bus", issue_bus, exp_bus);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
